// File: rtl/clk_d_mon_if.sv
// -----------------------------------------------------------------------------
// clk_d_mon_if
// Bundle between a divided-clock source and the clk_d_mon monitor.
//   clk_d        : divided clock under observation (source -> monitor)
//   rise_pls     : one-cycle pulse per detected clk_d rising edge
//   fall_pls     : one-cycle pulse per detected clk_d falling edge
//   period       : last measured rise-to-rise distance in clk cycles
//   high_time    : last measured rise-to-fall distance in clk cycles
//   meas_vld     : one-cycle pulse when period/high_time describe a full period
//   locked       : clk_d ratio currently matches the expected divider
//   err_timeout  : clk_d has stalled
// Modports: master = side that owns clk_d, slave = the monitor.
// -----------------------------------------------------------------------------
interface clk_d_mon_if #(
    parameter int CNT_W = 8
);
    logic             clk_d;
    logic             rise_pls;
    logic             fall_pls;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             meas_vld;
    logic             locked;
    logic             err_timeout;

    modport master (
        output clk_d,
        input  rise_pls,
        input  fall_pls,
        input  period,
        input  high_time,
        input  meas_vld,
        input  locked,
        input  err_timeout
    );

    modport slave (
        input  clk_d,
        output rise_pls,
        output fall_pls,
        output period,
        output high_time,
        output meas_vld,
        output locked,
        output err_timeout
    );
endinterface

// File: rtl/clk_d_mon.sv
// -----------------------------------------------------------------------------
// clk_d_mon
// Watches a divided clock (clk_d) that is asynchronous to the system clock,
// measures its period and high time in clk cycles, and reports whether the
// ratio matches DIV_NUM (locked) or whether clk_d has stopped (err_timeout).
//
// Ports:
//   clk  : system clock, all state on its rising edge
//   rst  : synchronous active-high reset
//   mon  : clk_d_mon_if.slave -- clk_d in, measurement/status outputs out
//
// Parameters:
//   DIV_NUM  : expected clk_d period in clk cycles (2..255)
//   CNT_W    : width of the counters and measurement outputs
//   LOCK_CNT : consecutive good periods needed to declare lock (1..15)
//   TIMEOUT  : clk cycles without a clk_d rise that count as a stall
// -----------------------------------------------------------------------------
module clk_d_mon #(
    parameter int DIV_NUM  = 2,
    parameter int CNT_W    = 8,
    parameter int LOCK_CNT = 4,
    parameter int TIMEOUT  = 255
) (
    input  logic        clk,
    input  logic        rst,
    clk_d_mon_if.slave  mon
);

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_TRACK  = 2'd1,
        ST_LOCK   = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] DIV_C   = CNT_W'(DIV_NUM);
    // An odd ratio sampled at 50% duty gives floor or ceil of half the period.
    localparam logic [CNT_W-1:0] HI_MIN  = CNT_W'(DIV_NUM / 2);
    localparam logic [CNT_W-1:0] HI_MAX  = CNT_W'((DIV_NUM + 1) / 2);
    localparam logic [CNT_W-1:0] TMO_C   = CNT_W'(TIMEOUT);
    localparam logic [3:0]       LOCK_C  = 4'(LOCK_CNT);

    // Saturating increment shared by both measurement counters.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        if (v == CNT_MAX) begin
            r = v;
        end else begin
            r = v + CNT_W'(1);
        end
        return r;
    endfunction

    // Synchronizer and edge history
    logic             sync1_q;
    logic             sync2_q;
    logic             prev_q;

    // Measurement datapath
    logic [CNT_W-1:0] per_cnt_q;
    logic [CNT_W-1:0] per_cnt_d;
    logic [CNT_W-1:0] hi_cnt_q;
    logic [CNT_W-1:0] hi_cnt_d;
    logic [CNT_W-1:0] high_time_q;
    logic [CNT_W-1:0] high_time_d;
    logic             rise_pls_q;
    logic             fall_pls_q;

    // Lock FSM and its registered outputs
    state_e           state_q;
    logic [3:0]       match_q;
    logic [CNT_W-1:0] period_q;
    logic             meas_vld_q;
    logic             locked_q;
    logic             err_q;

    // Decoded events for the current cycle
    logic             rise_s;
    logic             fall_s;
    logic             good_s;
    logic             timeout_s;

    // Edge detection, period quality and stall detection for this cycle.
    always_comb begin
        rise_s    = sync2_q & ~prev_q;
        fall_s    = ~sync2_q & prev_q;
        // high_time_q still holds the value from the fall inside the period
        // that is closing now; a fall can never coincide with a rise.
        good_s    = (per_cnt_q == DIV_C) &&
                    (high_time_q >= HI_MIN) && (high_time_q <= HI_MAX);
        // A rise in the same cycle wins over the stall condition.
        timeout_s = (state_q != ST_SEARCH) && (per_cnt_q >= TMO_C) && !rise_s;
    end

    // Next-state values for the period and high-time counters.
    always_comb begin
        per_cnt_d   = per_cnt_q;
        hi_cnt_d    = hi_cnt_q;
        high_time_d = high_time_q;

        if (rise_s) begin
            per_cnt_d = CNT_W'(1);
        end else begin
            per_cnt_d = sat_inc(per_cnt_q);
        end

        if (rise_s) begin
            hi_cnt_d = CNT_W'(1);
        end else if (sync2_q) begin
            hi_cnt_d = sat_inc(hi_cnt_q);
        end else begin
            hi_cnt_d = hi_cnt_q;
        end

        if (fall_s) begin
            high_time_d = hi_cnt_q;
        end else begin
            high_time_d = high_time_q;
        end
    end

    // Synchronizer, edge pulses and measurement counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            prev_q      <= 1'b0;
            per_cnt_q   <= '0;
            hi_cnt_q    <= '0;
            high_time_q <= '0;
            rise_pls_q  <= 1'b0;
            fall_pls_q  <= 1'b0;
        end else begin
            sync1_q     <= mon.clk_d;
            sync2_q     <= sync1_q;
            prev_q      <= sync2_q;
            per_cnt_q   <= per_cnt_d;
            hi_cnt_q    <= hi_cnt_d;
            high_time_q <= high_time_d;
            rise_pls_q  <= rise_s;
            fall_pls_q  <= fall_s;
        end
    end

    // Lock FSM: SEARCH waits for a first rise, TRACK counts good periods,
    // LOCK holds until a bad period or a stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_SEARCH;
            match_q    <= 4'd0;
            period_q   <= '0;
            meas_vld_q <= 1'b0;
            locked_q   <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            meas_vld_q <= 1'b0;
            // Lags the state by one cycle, except that a stall drops it at once.
            locked_q   <= (state_q == ST_LOCK) && !timeout_s;

            if (rise_s) begin
                err_q <= 1'b0;
                case (state_q)
                    ST_SEARCH: begin
                        // First rise only marks a reference point, nothing to measure.
                        state_q <= ST_TRACK;
                        match_q <= 4'd0;
                    end
                    ST_TRACK: begin
                        period_q   <= per_cnt_q;
                        meas_vld_q <= 1'b1;
                        if (good_s) begin
                            match_q <= match_q + 4'd1;
                            if ((match_q + 4'd1) >= LOCK_C) begin
                                state_q <= ST_LOCK;
                            end
                        end else begin
                            match_q <= 4'd0;
                        end
                    end
                    ST_LOCK: begin
                        period_q   <= per_cnt_q;
                        meas_vld_q <= 1'b1;
                        if (!good_s) begin
                            state_q <= ST_TRACK;
                            match_q <= 4'd0;
                        end
                    end
                    default: begin
                        state_q <= ST_SEARCH;
                        match_q <= 4'd0;
                    end
                endcase
            end else if (timeout_s) begin
                state_q <= ST_SEARCH;
                match_q <= 4'd0;
                err_q   <= 1'b1;
            end
        end
    end

    assign mon.rise_pls    = rise_pls_q;
    assign mon.fall_pls    = fall_pls_q;
    assign mon.period      = period_q;
    assign mon.high_time   = high_time_q;
    assign mon.meas_vld    = meas_vld_q;
    assign mon.locked      = locked_q;
    assign mon.err_timeout = err_q;

endmodule

// File: tb/tb_clk_d_mon.sv
// -----------------------------------------------------------------------------
// tb_clk_d_mon
// Two monitors: u_dut4 (DIV_NUM=4) driven by directed and random patterns,
// u_dut3 (DIV_NUM=3) watching a free-running 1.5-cycle half-period clock.
// A timestamp-based reference model predicts every output of both each cycle.
// -----------------------------------------------------------------------------
module tb_clk_d_mon;

    localparam int MAXC     = 12000;
    localparam int LOCK_CNT = 4;
    localparam int TIMEOUT  = 255;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clk_d4 = 1'b0;
    logic clk_d3_gen;

    always #5 clk = ~clk;

    // 30-unit period, offset so its edges never land on a clk edge.
    initial begin
        clk_d3_gen = 1'b0;
        #2;
        forever begin
            #15;
            clk_d3_gen = ~clk_d3_gen;
        end
    end

    clk_d_mon_if #(.CNT_W(8)) if4 ();
    clk_d_mon_if #(.CNT_W(8)) if3 ();

    assign if4.clk_d = clk_d4;
    assign if3.clk_d = clk_d3_gen;

    clk_d_mon #(.DIV_NUM(4), .CNT_W(8), .LOCK_CNT(LOCK_CNT), .TIMEOUT(TIMEOUT)) u_dut4 (
        .clk (clk),
        .rst (rst),
        .mon (if4.slave)
    );

    clk_d_mon #(.DIV_NUM(3), .CNT_W(8), .LOCK_CNT(LOCK_CNT), .TIMEOUT(TIMEOUT)) u_dut3 (
        .clk (clk),
        .rst (rst),
        .mon (if3.slave)
    );

    logic [20:0] obs4;
    logic [20:0] obs3;
    assign obs4 = {if4.rise_pls, if4.fall_pls, if4.meas_vld, if4.locked, if4.err_timeout,
                   if4.period, if4.high_time};
    assign obs3 = {if3.rise_pls, if3.fall_pls, if3.meas_vld, if3.locked, if3.err_timeout,
                   if3.period, if3.high_time};

    // ---------------- reference model (timestamps of detected edges) --------
    bit   hist [2][MAXC];
    int   t = 3;
    bit   m_valid = 1'b0;
    int   m_last_r [2];
    bit   m_have_r [2];
    int   m_state  [2];   // 0 search, 1 track, 2 lock
    int   m_match  [2];
    bit   m_rise [2], m_fall [2], m_meas [2], m_lock [2], m_err [2];
    int   m_per  [2], m_hi [2];
    int   divs   [2] = '{4, 3};

    function automatic int sat255(input int v);
        return (v > 255) ? 255 : v;
    endfunction

    always @(posedge clk) begin
        bit cur, rs, fl, good, tmo;
        int pr;
        if (t < MAXC - 1) t = t + 1;
        for (int u = 0; u < 2; u++) begin
            cur = (u == 0) ? clk_d4 : clk_d3_gen;
            if (rst) begin
                m_valid = 1'b1;
                hist[u][t] = 1'b0; hist[u][t-1] = 1'b0; hist[u][t-2] = 1'b0;
                m_state[u] = 0; m_match[u] = 0; m_have_r[u] = 1'b0;
                m_rise[u] = 1'b0; m_fall[u] = 1'b0; m_meas[u] = 1'b0;
                m_lock[u] = 1'b0; m_err[u] = 1'b0; m_per[u] = 0; m_hi[u] = 0;
            end else begin
                hist[u][t] = cur;
                // A level sampled at edge k is seen as an edge pulse at k+2.
                rs  = hist[u][t-2] && !hist[u][t-3];
                fl  = !hist[u][t-2] && hist[u][t-3];
                tmo = !rs && (m_state[u] != 0) && ((t - m_last_r[u]) >= TIMEOUT);
                m_lock[u] = (m_state[u] == 2) && !tmo;
                m_meas[u] = 1'b0;
                if (rs) begin
                    if (m_state[u] != 0) begin
                        pr = sat255(t - m_last_r[u]);
                        m_per[u]  = pr;
                        m_meas[u] = 1'b1;
                        good = (pr == divs[u]) && (m_hi[u] >= divs[u] / 2) &&
                               (m_hi[u] <= (divs[u] + 1) / 2);
                        if (m_state[u] == 1) begin
                            if (good) begin
                                m_match[u] = m_match[u] + 1;
                                if (m_match[u] >= LOCK_CNT) m_state[u] = 2;
                            end else begin
                                m_match[u] = 0;
                            end
                        end else if (!good) begin
                            m_state[u] = 1;
                            m_match[u] = 0;
                        end
                    end else begin
                        m_state[u] = 1;
                        m_match[u] = 0;
                    end
                    m_err[u]    = 1'b0;
                    m_last_r[u] = t;
                    m_have_r[u] = 1'b1;
                end else if (tmo) begin
                    m_state[u] = 0;
                    m_match[u] = 0;
                    m_err[u]   = 1'b1;
                end
                if (fl && m_have_r[u]) m_hi[u] = sat255(t - m_last_r[u]);
                m_rise[u] = rs;
                m_fall[u] = fl;
            end
        end
    end

    // ---------------- bookkeeping -------------------------------------------
    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    int rise_cnt, meas_cnt, first_per, fourth_meas_cyc, last_rise_cyc;
    bit lock_seen, unlock_seen, bad_seen, err_seen, prev_locked, err_locked;
    int lock_cyc, lock_rise, lock_meas, unlock_cyc, bad_cyc, bad_per, err_cyc, err_gap;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        logic [20:0] exp;
        @(negedge clk);
        cyc++;
        if (cyc > MAXC - 20) begin
            $display("FAIL watchdog: actual=%0d required<%0d", cyc, MAXC - 20);
            $fatal(1, "cycle budget exhausted");
        end
        if (m_valid) begin
            for (int u = 0; u < 2; u++) begin
                exp = {m_rise[u], m_fall[u], m_meas[u], m_lock[u], m_err[u],
                       m_per[u][7:0], m_hi[u][7:0]};
                chk($sformatf("model_u%0d@%0d", (u == 0) ? 4 : 3, cyc),
                    {11'd0, (u == 0) ? obs4 : obs3}, {11'd0, exp});
            end
        end
    endtask

    task automatic clr_mon();
        rise_cnt = 0; meas_cnt = 0; first_per = -1; fourth_meas_cyc = -1;
        lock_seen = 1'b0; unlock_seen = 1'b0; bad_seen = 1'b0; err_seen = 1'b0;
        lock_cyc = -1; lock_rise = -1; lock_meas = -1; unlock_cyc = -1;
        bad_cyc = -1; bad_per = -1; err_cyc = -1; err_gap = -1; err_locked = 1'b1;
    endtask

    task automatic drive_cyc(input logic v);
        clk_d4 = v;
        tick();
        if (if4.rise_pls) begin
            rise_cnt++;
            last_rise_cyc = cyc;
        end
        if (if4.meas_vld) begin
            meas_cnt++;
            if (meas_cnt == 1) first_per = int'(if4.period);
            if (meas_cnt == 4) fourth_meas_cyc = cyc;
            if (if4.period != 8'd4 && !bad_seen) begin
                bad_seen = 1'b1; bad_cyc = cyc; bad_per = int'(if4.period);
            end
        end
        if (if4.locked && !lock_seen) begin
            lock_seen = 1'b1; lock_cyc = cyc; lock_rise = rise_cnt; lock_meas = meas_cnt;
        end
        if (!if4.locked && prev_locked && !unlock_seen) begin
            unlock_seen = 1'b1; unlock_cyc = cyc;
        end
        prev_locked = if4.locked;
        if (if4.err_timeout && !err_seen) begin
            err_seen = 1'b1; err_cyc = cyc; err_locked = if4.locked;
            err_gap = cyc - last_rise_cyc;
        end
    endtask

    task automatic gen4(input int per, input int hi, input int n);
        for (int p = 0; p < n; p++) begin
            for (int c = 0; c < per; c++) drive_cyc((c < hi) ? 1'b1 : 1'b0);
        end
    endtask

    task automatic rst_pulse();
        rst = 1'b1;
        drive_cyc(clk_d4);
        rst = 1'b0;
    endtask

    typedef struct packed {
        logic       rst;
        logic       d;
        logic       rise;
        logic       fall;
        logic       meas;
        logic [7:0] per;
        logic [7:0] hi;
    } vec_t;

    vec_t tbl [11];

    initial begin
        int r, per, hi;
        // Post-reset edge pulses: held-high input, 2-edge latency, first measurements.
        tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0};
        tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0};
        tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0};
        tbl[3]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0};
        tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0, 8'd3};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd3};
        tbl[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'd5, 8'd3};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd5, 8'd3};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd5, 8'd2};

        prev_locked = 1'b0;
        last_rise_cyc = 0;
        clr_mon();

        rst = 1'b1;
        repeat (3) tick();
        chk("reset_u4", {11'd0, obs4}, 32'd0);
        chk("reset_u3", {11'd0, obs3}, 32'd0);

        for (int i = 0; i < 11; i++) begin
            rst    = tbl[i].rst;
            clk_d4 = tbl[i].d;
            tick();
            chk($sformatf("vec%0d", i),
                {13'd0, if4.rise_pls, if4.fall_pls, if4.meas_vld, if4.period, if4.high_time},
                {13'd0, tbl[i].rise, tbl[i].fall, tbl[i].meas, tbl[i].per, tbl[i].hi});
        end

        // Clean lock at ratio 4.
        clk_d4 = 1'b0;
        rst_pulse();
        clr_mon();
        gen4(4, 2, 8);
        chk("lock4_seen", {31'd0, lock_seen}, 32'd1);
        chk("lock4_delay", lock_cyc, fourth_meas_cyc + 1);
        chk("lock4_rises", lock_rise, 32'd5);
        chk("lock4_period", {24'd0, if4.period}, 32'd4);
        chk("lock4_high", {24'd0, if4.high_time}, 32'd2);

        // Ratio changes to 6 while locked.
        clr_mon();
        gen4(6, 3, 3);
        chk("bad_period", bad_per, 32'd6);
        chk("unlock_delay", unlock_cyc, bad_cyc + 1);

        // Relock, then stall clk_d low.
        gen4(4, 2, 7);
        chk("relock", {31'd0, if4.locked}, 32'd1);
        clr_mon();
        repeat (270) drive_cyc(1'b0);
        chk("stall_err_seen", {31'd0, err_seen}, 32'd1);
        chk("stall_gap", err_gap, 32'd255);
        chk("stall_unlocked_at_err", {31'd0, err_locked}, 32'd0);
        chk("stall_err_held", {31'd0, if4.err_timeout}, 32'd1);

        clr_mon();
        for (int i = 0; i < 3; i++) begin
            drive_cyc(1'b1);
            if (if4.rise_pls) begin
                chk("recover_err", {31'd0, if4.err_timeout}, 32'd0);
                chk("recover_no_meas", {31'd0, if4.meas_vld}, 32'd0);
            end
        end
        chk("recover_rises", rise_cnt, 32'd1);

        // Rise lands exactly when the period counter hits TIMEOUT.
        clr_mon();
        repeat (252) drive_cyc(1'b0);
        gen4(4, 2, 4);
        chk("tmo_tie_period", first_per, 32'd255);
        chk("tmo_tie_no_err", {31'd0, err_seen}, 32'd0);
        chk("tmo_tie_meas", meas_cnt, 32'd4);

        // Reset while locked.
        gen4(4, 2, 3);
        chk("lock_before_rst", {31'd0, if4.locked}, 32'd1);
        rst_pulse();
        chk("rst_mid_u4", {11'd0, obs4}, 32'd0);
        chk("rst_mid_u3", {11'd0, obs3}, 32'd0);
        clr_mon();
        gen4(4, 2, 8);
        chk("relock_rises", lock_rise, 32'd1 + LOCK_CNT);
        chk("relock_meas", lock_meas, LOCK_CNT);

        // Random mix of good/bad periods, stalls and resets.
        for (int s = 0; s < 60; s++) begin
            r = $urandom_range(0, 99);
            if (r < 60) begin
                gen4(4, 2, 1);
            end else if (r < 85) begin
                per = $urandom_range(2, 9);
                hi  = $urandom_range(1, per - 1);
                gen4(per, hi, 1);
            end else if (r < 93) begin
                repeat ($urandom_range(200, 300)) drive_cyc(1'b0);
            end else begin
                rst_pulse();
            end
        end

        gen4(4, 2, 10);
        chk("final_lock_u4", {31'd0, if4.locked}, 32'd1);
        chk("final_lock_u3", {31'd0, if3.locked}, 32'd1);
        chk("final_period_u3", {24'd0, if3.period}, 32'd3);
        chk("final_high_u3_range",
            {31'd0, (if3.high_time == 8'd1) || (if3.high_time == 8'd2)}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
